// File: rtl/fp_cmp_issue.sv
`default_nettype none
// ============================================================================
// Module   : fp_cmp_issue
// Purpose  : Issues FP compare requests to an external fixed-latency comparator,
//            decodes its flags into predicate results and queues them in order.
// Revision : 1.0
// ============================================================================
module fp_cmp_issue #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_tag,
  output logic        cmp_go,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  input  logic        cmp_done,
  input  logic [2:0]  cmp_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_result,
  output logic [3:0]  out_tag,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = $clog2(LATENCY + 1);

  localparam logic [2:0] OP_EQ = 3'd0;
  localparam logic [2:0] OP_NE = 3'd1;
  localparam logic [2:0] OP_LT = 3'd2;
  localparam logic [2:0] OP_LE = 3'd3;
  localparam logic [2:0] OP_GT = 3'd4;
  localparam logic [2:0] OP_GE = 3'd5;

  logic              rdy_en_q;
  logic [CW-1:0]     credits_q, credits_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     mask_q;
  logic [LATENCY:0]  pv_q;
  logic [2:0]        pop_q  [LATENCY+1];
  logic [3:0]        ptag_q [LATENCY+1];
  logic [31:0]       a_q, b_q;
  logic              res_mem [DEPTH];
  logic [3:0]        tag_mem [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic              err_q, err_d;
  logic              accept, pop, masked, wr, swap, wr_res;

  // Flags are bit0=aeb, bit1=alb, bit2=aleb; GT/GE already see swapped operands.
  function automatic logic decode(input logic [2:0] op, input logic [2:0] f);
    case (op)
      OP_EQ:   decode = f[0];
      OP_NE:   decode = ~f[0];
      OP_LT:   decode = f[1];
      OP_LE:   decode = f[2];
      OP_GT:   decode = f[1];
      OP_GE:   decode = f[2];
      default: decode = 1'b0;
    endcase
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    nxt = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready = rdy_en_q & (credits_q != '0);
  assign accept   = in_valid & in_ready;
  assign out_valid = (cnt_q != '0);
  assign pop      = out_valid & out_ready;
  assign masked   = (mask_q != '0);
  assign wr       = pv_q[LATENCY] & ~masked;
  assign swap     = (in_op == OP_GT) | (in_op == OP_GE);
  assign wr_res   = decode(pop_q[LATENCY], cmp_res);

  always_comb begin
    credits_d = credits_q;
    if (accept & ~pop)      credits_d = credits_q - CW'(1);
    else if (pop & ~accept) credits_d = credits_q + CW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr & ~pop)      cnt_d = cnt_q + CW'(1);
    else if (pop & ~wr) cnt_d = cnt_q - CW'(1);
  end

  // Stale comparator pulses from before reset are ignored while the mask runs.
  assign err_d = err_q | (accept & (in_op > OP_GE))
               | (~masked & (cmp_done != pv_q[LATENCY]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_en_q  <= 1'b0;
      credits_q <= CW'(DEPTH);
      cnt_q     <= '0;
      mask_q    <= MW'(LATENCY);
      pv_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k <= LATENCY; k++) begin
        pop_q[k]  <= '0;
        ptag_q[k] <= '0;
      end
    end else begin
      rdy_en_q  <= 1'b1;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      if (masked) mask_q <= mask_q - MW'(1);
      pv_q[0] <= accept;
      if (accept) begin
        pop_q[0]  <= in_op;
        ptag_q[0] <= in_tag;
        a_q       <= swap ? in_b : in_a;
        b_q       <= swap ? in_a : in_b;
      end
      for (int k = 1; k <= LATENCY; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pop_q[k]  <= pop_q[k-1];
        ptag_q[k] <= ptag_q[k-1];
      end
      if (wr)  wptr_q <= nxt(wptr_q);
      if (pop) rptr_q <= nxt(rptr_q);
    end
  end

  always_ff @(posedge clock) begin
    if (wr) begin
      res_mem[wptr_q] <= wr_res;
      tag_mem[wptr_q] <= ptag_q[LATENCY];
    end
  end

  assign cmp_go     = pv_q[0];
  assign cmp_a      = a_q;
  assign cmp_b      = b_q;
  assign out_result = out_valid & res_mem[rptr_q];
  assign out_tag    = out_valid ? tag_mem[rptr_q] : 4'd0;
  assign err        = err_q;

endmodule
`default_nettype wire
